// File: rtl/parametrised_control_hazard_tracker_pkg.sv
// Shared trigger-stage types: destination encodings and the in-flight record
// that the control hazard tracker shifts down the pipeline.
package parametrised_control_hazard_tracker_pkg;

    localparam int TIA_DT_WIDTH = 3;
    localparam int TIA_DI_WIDTH = 4;

    localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_PREDICATE = 3'd2;

    typedef struct packed {
        logic                    valid;
        logic [TIA_DT_WIDTH-1:0] dt;
        logic [TIA_DI_WIDTH-1:0] di;
    } hazard_record_t;

    function automatic logic is_predicate_write(input hazard_record_t rec);
        return rec.valid && (rec.dt == TIA_DESTINATION_TYPE_PREDICATE);
    endfunction

endpackage

// File: rtl/parametrised_control_hazard_tracker_if.sv
// Issue-side handshake between the trigger-resolution stage (master) and the
// control hazard tracker (slave).
interface parametrised_control_hazard_tracker_if #(
    parameter int NUM_PREDICATES = 8
);
    import parametrised_control_hazard_tracker_pkg::*;

    logic                      issue_valid;
    logic [TIA_DT_WIDTH-1:0]   issue_dt;
    logic [TIA_DI_WIDTH-1:0]   issue_di;
    logic [NUM_PREDICATES-1:0] predicate_read_mask;
    logic                      hazard;
    logic                      issue_accepted;

    modport master (
        output issue_valid, issue_dt, issue_di, predicate_read_mask,
        input  hazard, issue_accepted
    );

    modport slave (
        input  issue_valid, issue_dt, issue_di, predicate_read_mask,
        output hazard, issue_accepted
    );

endinterface

// File: rtl/parametrised_control_hazard_tracker_hazard_record_match.sv
// Per-record check: does this in-flight record write a predicate, and does that
// write collide with what the trigger stage is reading right now.
module hazard_record_match
    import parametrised_control_hazard_tracker_pkg::*;
#(
    parameter int NUM_PREDICATES = 8,
    parameter int PRECISE        = 1
) (
    input  hazard_record_t              record,
    input  logic [NUM_PREDICATES-1:0]   read_mask,
    output logic                        hit,
    output logic [NUM_PREDICATES-1:0]   pending_mask
);

    logic                      pred_write;
    logic                      in_range;
    logic [NUM_PREDICATES-1:0] one_hot;

    always_comb begin
        pred_write = is_predicate_write(record);
        in_range   = 1'b0;
        one_hot    = '0;
        // Decode by comparison so an index wider than the mask never selects out of range.
        for (int p = 0; p < NUM_PREDICATES; p++) begin
            if (int'(record.di) == p) begin
                one_hot[p] = 1'b1;
                in_range   = 1'b1;
            end
        end

        pending_mask = pred_write ? one_hot : '0;

        if (PRECISE != 0) begin
            // An index the trigger stage cannot see is assumed to matter.
            hit = pred_write && (!in_range || (|(one_hot & read_mask)));
        end else begin
            hit = pred_write;
        end
    end

endmodule

// File: rtl/parametrised_control_hazard_tracker.sv
// Tracks in-flight destination records beside the trigger-resolution stage and
// blocks issue while a pending predicate write could change the trigger outcome.
module parametrised_control_hazard_tracker
    import parametrised_control_hazard_tracker_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int NUM_PREDICATES = 8,
    parameter int PRECISE        = 1,
    parameter int COUNTER_WIDTH  = 16,
    localparam int OCC_WIDTH     = $clog2(NUM_STAGES + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        advance,
    input  logic                        flush,
    input  logic                        counter_clear,
    parametrised_control_hazard_tracker_if.slave issue_if,
    output logic [NUM_PREDICATES-1:0]   in_flight_predicate_mask,
    output logic [OCC_WIDTH-1:0]        occupancy,
    output logic [COUNTER_WIDTH-1:0]    hazard_cycles
);

    hazard_record_t entry_q [NUM_STAGES];
    hazard_record_t entry_d [NUM_STAGES];

    logic [COUNTER_WIDTH-1:0]  hazard_cycles_q;
    logic [COUNTER_WIDTH-1:0]  hazard_cycles_d;
    logic                      running_q;
    logic                      running_d;

    logic [NUM_STAGES-1:0]     record_hit;
    logic [NUM_PREDICATES-1:0] record_pending [NUM_STAGES];
    logic                      hazard;
    logic                      issue_accepted;
    hazard_record_t            new_record;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
            hazard_record_match #(
                .NUM_PREDICATES (NUM_PREDICATES),
                .PRECISE        (PRECISE)
            ) u_match (
                .record       (entry_q[gi]),
                .read_mask    (issue_if.predicate_read_mask),
                .hit          (record_hit[gi]),
                .pending_mask (record_pending[gi])
            );
        end
    endgenerate

    assign hazard = |record_hit;

    // running_q keeps issue closed until the first edge after reset release.
    assign issue_accepted = running_q && issue_if.issue_valid && advance && !hazard && !flush;

    assign issue_if.hazard         = hazard;
    assign issue_if.issue_accepted = issue_accepted;

    always_comb begin
        new_record.valid = issue_accepted;
        new_record.dt    = issue_if.issue_dt;
        new_record.di    = issue_if.issue_di;
    end

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                entry_d[i] = '0;
            end
        end else if (advance) begin
            entry_d[0] = new_record;
            for (int i = 1; i < NUM_STAGES; i++) begin
                entry_d[i] = entry_q[i-1];
            end
        end
    end

    always_comb begin
        running_d = 1'b1;
        if (counter_clear) begin
            hazard_cycles_d = '0;
        end else if (hazard && !(&hazard_cycles_q)) begin
            hazard_cycles_d = hazard_cycles_q + COUNTER_WIDTH'(1);
        end else begin
            hazard_cycles_d = hazard_cycles_q;
        end
    end

    always_comb begin
        in_flight_predicate_mask = '0;
        occupancy                = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            in_flight_predicate_mask = in_flight_predicate_mask | record_pending[i];
            if (entry_q[i].valid) begin
                occupancy = occupancy + OCC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                entry_q[i] <= '0;
            end
            hazard_cycles_q <= '0;
            running_q       <= 1'b0;
        end else begin
            entry_q         <= entry_d;
            hazard_cycles_q <= hazard_cycles_d;
            running_q       <= running_d;
        end
    end

    assign hazard_cycles = hazard_cycles_q;

endmodule
